// File: rtl/mips_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : mips_regfile_sb
// Purpose  : MIPS general-purpose register file with a per-register
//            pending-write scoreboard and a self-sequencing clear engine
//            that zeroes every register after reset.
// Ports    : Clk, Rst          - clock / synchronous active-low reset
//            RdAddr1/2         - read addresses (combinational read)
//            RdData1/2         - read data, optional same-cycle write bypass
//            Pend1/2           - outstanding-write flag of the read register
//            WrEn/WrAddr/WrData- writeback port (clears pending)
//            IssueEn/IssueAddr - issue port (sets pending)
//            Busy              - clear sequence running, requests ignored
// Revision : 1.0 - initial release
// ============================================================================
module mips_regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] RdAddr1,
    input  logic [ADDR_W-1:0] RdAddr2,
    output logic [DATA_W-1:0] RdData1,
    output logic [DATA_W-1:0] RdData2,
    output logic              Pend1,
    output logic              Pend2,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              IssueEn,
    input  logic [ADDR_W-1:0] IssueAddr,
    output logic              Busy
);

    localparam int unsigned      c_NREGS = 2 ** ADDR_W;
    // Counter is one bit wider than an address so the full count is representable.
    localparam logic [ADDR_W:0]  c_LAST  = (ADDR_W + 1)'(c_NREGS - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [c_NREGS-1:0]  pend_q, pend_d;
    logic [DATA_W-1:0]   regs_q [c_NREGS];

    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_wr_zero;
    logic                w_iss_zero;

    // Writes/issues to register 0 are discarded when it is hardwired.
    assign w_wr_zero  = ZERO_REG && (WrAddr == '0);
    assign w_iss_zero = ZERO_REG && (IssueAddr == '0);

    // ------------------------------------------------------------------------
    // State, counter and scoreboard registers
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic; the clear engine and writeback share one write port
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        w_we    = 1'b0;
        w_waddr = WrAddr;
        w_wdata = WrData;
        case (state_q)
            S_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = cnt_q[ADDR_W-1:0];
                w_wdata = '0;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == c_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                w_we = WrEn && !w_wr_zero;
                // Clear first, then set: a same-cycle issue to the same
                // register belongs to a younger instruction and must win.
                if (WrEn) begin
                    pend_d[WrAddr] = 1'b0;
                end
                if (IssueEn && !w_iss_zero) begin
                    pend_d[IssueAddr] = 1'b1;
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    // Storage has no reset; contents are defined by the clear sequence.
    always_ff @(posedge Clk) begin
        if (w_we) begin
            regs_q[w_waddr] <= w_wdata;
        end
    end

    assign Busy = (state_q == S_CLEAR);

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_pend;
        logic              w_hit;

        assign w_addr = (p == 0) ? RdAddr1 : RdAddr2;
        // Forwarded write: data is taken from the writeback bus and the
        // pending flag is masked because the result is already available.
        assign w_hit  = BYPASS && WrEn && !w_wr_zero && (WrAddr == w_addr);

        always_comb begin
            w_data = '0;
            w_pend = 1'b0;
            if (state_q == S_RUN) begin
                if (ZERO_REG && (w_addr == '0)) begin
                    w_data = '0;
                end else if (w_hit) begin
                    w_data = WrData;
                end else begin
                    w_data = regs_q[w_addr];
                end
                w_pend = w_hit ? 1'b0 : pend_q[w_addr];
            end
        end
    end

    assign RdData1 = g_rd_port[0].w_data;
    assign RdData2 = g_rd_port[1].w_data;
    assign Pend1   = g_rd_port[0].w_pend;
    assign Pend2   = g_rd_port[1].w_pend;

endmodule
`default_nettype wire
